singleton_elim_scheduler: RTL and testbench

Round-robin scheduler that shares one singleton-elimination datapath (`singletonElimination`, 1-cycle latency, no stall input) among `NUM_PORTS` graph producers. The scheduler sits between the per-lane graph generators and the downstream component-exploration stage. It grants one 128-bit graph per cycle and tracks the in-flight result. Each result is buffered with its source port id in a credit-protected FIFO, so downstream backpressure never drops a datapath output.

---
 rtl/singleton_sched_pkg.sv | 49 ++++
 rtl/singletonElimination.sv | 34 +++
 rtl/singleton_result_fifo.sv | 62 ++++++
 rtl/singleton_elim_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_singleton_elim_scheduler.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/singleton_sched_pkg.sv
// -----------------------------------------------------------------------------
// singleton_sched_pkg
// Shared types and helpers for the singleton-elimination scheduler slice.
//   GRAPH_W        : width of one graph (128 vertices, 7-bit vertex ids)
//   COUNT_W        : width of the removed-singleton count
//   graph_t        : one graph, bit v set means vertex v is present
//   sched_result_t : one buffered result {graph, count, empty, port}
//   RESULT_IDLE    : value presented on the result head when nothing is buffered
//   singletonMask  : vertices present in the graph with no present neighbour
// Two vertices are adjacent when their 7-bit ids differ in exactly one bit.
// -----------------------------------------------------------------------------
package singleton_sched_pkg;

  localparam int GRAPH_W  = 128;
  localparam int COUNT_W  = 6;
  localparam int VERTEX_W = 7;

  typedef logic [GRAPH_W-1:0] graph_t;

  typedef struct packed {
    graph_t     graph;
    logic [5:0] count;
    logic       empty;
    logic [2:0] port;
  } sched_result_t;

  localparam sched_result_t RESULT_IDLE = '{graph: '0, count: '0, empty: 1'b1, port: '0};

  // A vertex is a singleton when it is present and none of its seven
  // one-bit-flip neighbours are present.
  function automatic graph_t singletonMask(input graph_t g);
    graph_t              m;
    logic                nb;
    logic [VERTEX_W-1:0] vi;
    logic [VERTEX_W-1:0] ni;
    m = '0;
    for (int v = 0; v < GRAPH_W; v++) begin
      vi = VERTEX_W'(v);
      nb = 1'b0;
      for (int k = 0; k < VERTEX_W; k++) begin
        ni = vi ^ (VERTEX_W'(1) << k);
        nb = nb | g[ni];
      end
      m[vi] = g[vi] & ~nb;
    end
    return m;
  endfunction

endpackage

// File: rtl/singletonElimination.sv
// -----------------------------------------------------------------------------
// singletonElimination
// Removes isolated vertices from a graph; one-cycle latency, no stall.
//   clk              : clock
//   graph_i          : graph presented this cycle
//   nonSingletons_o  : graph_i with its singletons cleared, one cycle later
//   singletonCount_o : number of singletons removed (wraps at 64), one cycle later
// -----------------------------------------------------------------------------
module singletonElimination
  import singleton_sched_pkg::*;
(
  input  logic               clk,
  input  graph_t             graph_i,
  output graph_t             nonSingletons_o,
  output logic [COUNT_W-1:0] singletonCount_o
);

  graph_t             singles;
  graph_t             nonSingletons_q;
  logic [COUNT_W-1:0] singletonCount_q;

  assign singles = singletonMask(graph_i);

  // Output register; results for idle cycles are ignored by the scheduler,
  // so no reset is needed here.
  always_ff @(posedge clk) begin
    nonSingletons_q  <= graph_i & ~singles;
    singletonCount_q <= COUNT_W'($countones(singles));
  end

  assign nonSingletons_o  = nonSingletons_q;
  assign singletonCount_o = singletonCount_q;

endmodule

// File: rtl/singleton_result_fifo.sv
// -----------------------------------------------------------------------------
// singleton_result_fifo
// Synchronous FIFO of sched_result_t with extra-bit wrap pointers.
//   clk, rst  : clock, synchronous active-high reset (pointers only)
//   wr_en_i   : write wr_data_i at this edge
//   wr_data_i : result to buffer
//   pop_i     : advance head at this edge (ignored while empty)
//   head_o    : oldest result, RESULT_IDLE while empty
//   empty_o   : nothing buffered
//   full_o    : all DEPTH entries hold results
// -----------------------------------------------------------------------------
module singleton_result_fifo
  import singleton_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  sched_result_t wr_data_i,
  input  logic          pop_i,
  output sched_result_t head_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int AW = $clog2(DEPTH);

  sched_result_t mem_q [DEPTH];
  logic [AW:0]   wrPtr_q;
  logic [AW:0]   rdPtr_q;

  // The extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // Pointer update; reset discards every buffered entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (wr_en_i) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop_i && !empty_o) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset; a write during reset is suppressed so nothing
  // half-lands in the array.
  always_ff @(posedge clk) begin
    if (wr_en_i && !rst) begin
      mem_q[wrPtr_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign head_o = empty_o ? RESULT_IDLE : mem_q[rdPtr_q[AW-1:0]];

endmodule

// File: rtl/singleton_elim_scheduler.sv
// -----------------------------------------------------------------------------
// singleton_elim_scheduler
// Round-robin sharing of one singletonElimination datapath among NUM_PORTS
// graph producers, with a credit-protected result FIFO toward downstream.
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : per-port graph valid
//   in_ready   : per-port grant, one-hot or zero
//   in_graph   : port p graph on [128*p +: 128]
//   out_valid  : result available at the FIFO head
//   out_ready  : downstream accepts the head result
//   out_graph  : non-singleton vertices of the result graph
//   out_count  : number of singletons removed
//   out_empty  : out_graph == 0
//   out_port   : source port of the result
// Optional build macro SINGLETON_SCHED_STATS_EN adds:
//   stat_graphs     : 32-bit wrapping count of pops
//   stat_singletons : 48-bit wrapping sum of out_count over pops
// -----------------------------------------------------------------------------
module singleton_elim_scheduler
  import singleton_sched_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PORTS-1:0]         in_valid,
  output logic [NUM_PORTS-1:0]         in_ready,
  input  logic [NUM_PORTS*128-1:0]     in_graph,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [127:0]                 out_graph,
  output logic [5:0]                   out_count,
  output logic                         out_empty,
  output logic [$clog2(NUM_PORTS)-1:0] out_port
`ifdef SINGLETON_SCHED_STATS_EN
  ,
  output logic [31:0]                  stat_graphs,
  output logic [47:0]                  stat_singletons
`endif
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);

  logic [PORT_W-1:0] rr_q, rr_d;
  logic [CRED_W-1:0] credits_q, credits_d;
  logic              inflightV_q;
  logic [PORT_W-1:0] inflightPort_q;

  logic [PORT_W:0]    cand;
  logic [PORT_W-1:0]  grantIdx;
  logic               grantFound;
  logic               accept;
  logic               pop;
  graph_t             selGraph;
  graph_t             dpGraph;
  logic [COUNT_W-1:0] dpCount;
  sched_result_t      wrData;
  sched_result_t      head;
  logic               fifoEmpty;
  logic               fifoFull;
  logic               unusedPortBits;

  // Round-robin search: first valid port at or after rr, wrapping.
  always_comb begin
    cand       = '0;
    grantFound = 1'b0;
    grantIdx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, rr_q} + (PORT_W+1)'(i);
      if (cand >= (PORT_W+1)'(NUM_PORTS)) begin
        cand = cand - (PORT_W+1)'(NUM_PORTS);
      end
      if (!grantFound && in_valid[cand[PORT_W-1:0]]) begin
        grantFound = 1'b1;
        grantIdx   = cand[PORT_W-1:0];
      end
    end
  end

  // Grant only with a free credit, so every accepted graph owns a FIFO slot.
  always_comb begin
    in_ready = '0;
    if (!rst && grantFound && (credits_q != '0)) begin
      in_ready[grantIdx] = 1'b1;
    end
  end

  assign accept    = |in_ready;
  assign out_valid = !fifoEmpty;
  assign pop       = out_valid && out_ready;

  // Next pointer and credit values; accept and pop together cancel out.
  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (grantIdx == PORT_W'(NUM_PORTS - 1)) ? '0 : grantIdx + 1'b1;
    end
    credits_d = credits_q;
    case ({accept, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  // Scheduler state; inflightV_q marks that the datapath output next cycle
  // belongs to an accepted graph.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q           <= '0;
      credits_q      <= CRED_W'(FIFO_DEPTH);
      inflightV_q    <= 1'b0;
      inflightPort_q <= '0;
    end else begin
      rr_q        <= rr_d;
      credits_q   <= credits_d;
      inflightV_q <= accept;
      if (accept) begin
        inflightPort_q <= grantIdx;
      end
    end
  end

  assign selGraph = in_graph[GRAPH_W*grantIdx +: GRAPH_W];

  singletonElimination uDatapath (
    .clk              (clk),
    .graph_i          (selGraph),
    .nonSingletons_o  (dpGraph),
    .singletonCount_o (dpCount)
  );

  assign wrData.graph = dpGraph;
  assign wrData.count = dpCount;
  assign wrData.empty = (dpGraph == '0);
  assign wrData.port  = 3'(inflightPort_q);

  singleton_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (inflightV_q),
    .wr_data_i (wrData),
    .pop_i     (pop),
    .head_o    (head),
    .empty_o   (fifoEmpty),
    .full_o    (fifoFull)
  );

  // Credits reserve the slot at accept time, so a write can never meet a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst && inflightV_q) begin
      assert (!fifoFull);
    end
  end

  assign out_graph      = head.graph;
  assign out_count      = head.count;
  assign out_empty      = head.empty;
  assign out_port       = head.port[PORT_W-1:0];
  assign unusedPortBits = ^head.port;

`ifdef SINGLETON_SCHED_STATS_EN
  logic [31:0] statGraphs_q;
  logic [47:0] statSingletons_q;

  // Pop statistics, both wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      statGraphs_q     <= '0;
      statSingletons_q <= '0;
    end else if (pop) begin
      statGraphs_q     <= statGraphs_q + 32'd1;
      statSingletons_q <= statSingletons_q + 48'(out_count);
    end
  end

  assign stat_graphs     = statGraphs_q;
  assign stat_singletons = statSingletons_q;
`endif

endmodule

// File: tb/tb_singleton_elim_scheduler.sv
// -----------------------------------------------------------------------------
// tb_singleton_elim_scheduler
// Scoreboard bench: each accepted graph pushes its modelled result; results
// are compared at the FIFO head and popped when downstream takes them.
// -----------------------------------------------------------------------------
module tb_singleton_elim_scheduler;

  localparam int NUM_PORTS  = 2;
  localparam int FIFO_DEPTH = 4;

  typedef struct packed {
    logic [127:0] graph;
    logic [5:0]   count;
    logic         empty;
    logic         port;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_PORTS-1:0]     in_valid = '0;
  logic [NUM_PORTS-1:0]     in_ready;
  logic [NUM_PORTS*128-1:0] in_graph = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [127:0]             out_graph;
  logic [5:0]               out_count;
  logic                     out_empty;
  logic                     out_port;
`ifdef SINGLETON_SCHED_STATS_EN
  logic [31:0]              stat_graphs;
  logic [47:0]              stat_singletons;
`endif

  singleton_elim_scheduler #(
    .NUM_PORTS  (NUM_PORTS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_graph  (in_graph),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_graph (out_graph),
    .out_count (out_count),
    .out_empty (out_empty),
    .out_port  (out_port)
`ifdef SINGLETON_SCHED_STATS_EN
    ,
    .stat_graphs     (stat_graphs),
    .stat_singletons (stat_singletons)
`endif
  );

  always #5 clk = ~clk;

  int          totalChecks = 0;
  int          badChecks   = 0;
  exp_t        expQ[$];
  int          grantLog[$];
  int          popCount = 0;
  logic [47:0] expSingletons = '0;
  bit          randReady = 1'b0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: brute-force over all vertex pairs at Hamming distance one.
  function automatic exp_t modelResult(input logic [127:0] g, input int port);
    exp_t         r;
    logic [127:0] single;
    int           n;
    bit           iso;
    single = '0;
    n      = 0;
    for (int v = 0; v < 128; v++) begin
      if (g[v]) begin
        iso = 1'b1;
        for (int u = 0; u < 128; u++) begin
          if (g[u] && ($countones(u ^ v) == 1)) iso = 1'b0;
        end
        if (iso) begin
          single[v] = 1'b1;
          n++;
        end
      end
    end
    r.graph = g & ~single;
    r.count = 6'(n);
    r.empty = (r.graph == '0);
    r.port  = 1'(port);
    return r;
  endfunction

  function automatic logic [127:0] randGraph();
    logic [127:0] a, b, c;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    c = {$urandom, $urandom, $urandom, $urandom};
    return a & b & c;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      expQ.delete();
      popCount      = 0;
      expSingletons = '0;
    end else begin
      if (expQ.size() == 0) begin
        checkOutput("stale_valid", 128'(out_valid), 128'(0));
      end else if (out_valid) begin
        checkOutput("sb_graph", out_graph, expQ[0].graph);
        checkOutput("sb_count", 128'(out_count), 128'(expQ[0].count));
        checkOutput("sb_empty", 128'(out_empty), 128'(expQ[0].empty));
        checkOutput("sb_port", 128'(out_port), 128'(expQ[0].port));
        if (out_ready) begin
          popCount++;
          expSingletons = expSingletons + 48'(expQ[0].count);
          void'(expQ.pop_front());
        end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (in_valid[p] && in_ready[p]) begin
          expQ.push_back(modelResult(in_graph[p*128 +: 128], p));
          grantLog.push_back(p);
        end
      end
    end
  end

  // Runs traffic; an accepted port gets a fresh graph right after its edge.
  task automatic applyStimulus(input int cycles);
    logic [NUM_PORTS-1:0] acc;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (acc[p]) in_graph[p*128 +: 128] = randGraph();
      end
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic drainQueue();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (expQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput("drain", 128'(expQ.size()), 128'(0));
  endtask

  // One graph from one port with explicit expected fields and latency.
  task automatic directedOne(input int port, input logic [127:0] g, input logic [127:0] eg,
                             input logic [5:0] ec, input logic ee);
    in_valid = '0;
    in_valid[port] = 1'b1;
    in_graph[port*128 +: 128] = g;
    @(negedge clk);
    checkOutput("dir_grant", 128'(in_ready), 128'(1 << port));
    @(posedge clk);
    #1;
    in_valid = '0;
    @(negedge clk);
    checkOutput("dir_lat_early", 128'(out_valid), 128'(0));
    @(negedge clk);
    checkOutput("dir_lat_valid", 128'(out_valid), 128'(1));
    checkOutput("dir_graph", out_graph, eg);
    checkOutput("dir_count", 128'(out_count), 128'(ec));
    checkOutput("dir_empty", 128'(out_empty), 128'(ee));
    checkOutput("dir_port", 128'(out_port), 128'(port));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    in_valid = 2'b11;
    in_graph = {128'h3, 128'h1};
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_out_graph", out_graph, 128'(0));
    checkOutput("rst_out_count", 128'(out_count), 128'(0));
    checkOutput("rst_out_port", 128'(out_port), 128'(0));
    checkOutput("rst_out_empty", 128'(out_empty), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = '0;

    directedOne(0, 128'h1, 128'h0, 6'd1, 1'b1);
    directedOne(1, 128'h3, 128'h3, 6'd0, 1'b0);
    directedOne(0, 128'h9, 128'h0, 6'd2, 1'b1);
    directedOne(1, {128{1'b1}}, {128{1'b1}}, 6'd0, 1'b0);

    // Both ports saturated: strict alternation at one accept per cycle.
    grantLog.delete();
    in_graph = {randGraph(), randGraph()};
    in_valid = 2'b11;
    applyStimulus(20);
    in_valid = '0;
    checkOutput("alt_accepts", 128'(grantLog.size()), 128'(20));
    for (int i = 0; i < grantLog.size(); i++) begin
      checkOutput($sformatf("alt_grant%0d", i), 128'(grantLog[i]), 128'(i % 2));
    end
    drainQueue();

    // Downstream stalled: credits allow exactly FIFO_DEPTH accepts.
    out_ready = 1'b0;
    grantLog.delete();
    in_valid = 2'b11;
    applyStimulus(10);
    checkOutput("bp_accepts", 128'(grantLog.size()), 128'(FIFO_DEPTH));
    @(negedge clk);
    checkOutput("bp_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    grantLog.delete();
    applyStimulus(10);
    in_valid = '0;
    checkOutput("bp_resume", 128'(grantLog.size()), 128'(9));
    drainQueue();

    // Reset with two results buffered and one in flight.
    out_ready = 1'b0;
    in_valid = 2'b01;
    applyStimulus(3);
`ifdef SINGLETON_SCHED_STATS_EN
    checkOutput("stat_graphs_pre", 128'(stat_graphs), 128'(popCount));
    checkOutput("stat_sing_pre", 128'(stat_singletons), 128'(expSingletons));
`endif
    rst = 1'b1;
    in_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("mid_rst_credits", 128'(dut.credits_q), 128'(FIFO_DEPTH));
`ifdef SINGLETON_SCHED_STATS_EN
    checkOutput("mid_rst_stat_graphs", 128'(stat_graphs), 128'(0));
`endif
    @(posedge clk);
    #1;

    // Mixed traffic with random downstream backpressure.
    randReady = 1'b1;
    in_valid = 2'b11;
    applyStimulus(40);
    randReady = 1'b0;
    in_valid = '0;
    drainQueue();
`ifdef SINGLETON_SCHED_STATS_EN
    checkOutput("stat_graphs_end", 128'(stat_graphs), 128'(popCount));
    checkOutput("stat_sing_end", 128'(stat_singletons), 128'(expSingletons));
`endif

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
